// File: rtl/pwrite_shift.sv
// rtl/pwrite_shift.sv - word-to-byte serializer with one-word holding register
// Accepts WRITE_WIDTH words on din and streams OUT_WIDTH-bit bytes on dout.
module pwrite_shift #(
    parameter int WRITE_WIDTH = 32,
    parameter int OUT_WIDTH   = 8,
    parameter bit MSB_FIRST   = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [WRITE_WIDTH-1:0] din,
    input  logic                   din_valid,
    output logic                   din_ready,
    output logic [OUT_WIDTH-1:0]   dout,
    output logic                   dout_valid,
    input  logic                   dout_ready,
    output logic                   dout_last,
    output logic                   busy,
    output logic                   done
);

    localparam int NBYTES = WRITE_WIDTH / OUT_WIDTH;
    localparam int CW     = $clog2(NBYTES);
    localparam logic [CW-1:0] CNT_MAX = CW'(NBYTES - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_SHIFT = 2'd1,
        ST_LAST  = 2'd2
    } state_t;

    logic [WRITE_WIDTH-1:0] r_sr;
    logic                   r_sv;
    logic [CW-1:0]          r_cnt;
    logic [WRITE_WIDTH-1:0] r_hr;
    logic                   r_hv;
    logic                   r_done;

    logic [WRITE_WIDTH-1:0] w_sr_nxt;
    logic                   w_sv_nxt;
    logic [CW-1:0]          w_cnt_nxt;
    logic [WRITE_WIDTH-1:0] w_hr_nxt;
    logic                   w_hv_nxt;
    logic                   w_done_nxt;

    state_t                 w_state;
    logic                   w_accept;
    logic                   w_xfer;
    logic [WRITE_WIDTH-1:0] w_shifted;
    logic [OUT_WIDTH-1:0]   w_byte;

    // Shifting moves the next byte into the output slice chosen by MSB_FIRST.
    generate
        if (MSB_FIRST) begin : g_msb
            assign w_shifted = r_sr << OUT_WIDTH;
            assign w_byte    = r_sr[WRITE_WIDTH-1 -: OUT_WIDTH];
        end else begin : g_lsb
            assign w_shifted = r_sr >> OUT_WIDTH;
            assign w_byte    = r_sr[OUT_WIDTH-1:0];
        end
    endgenerate

    assign din_ready  = !r_hv;
    assign w_accept   = din_valid && !r_hv;
    assign w_xfer     = r_sv && dout_ready;

    assign dout_valid = r_sv;
    assign dout_last  = r_sv && (r_cnt == '0);
    assign dout       = r_sv ? w_byte : '0;
    assign busy       = r_sv || r_hv;
    assign done       = r_done;

    always_comb begin
        w_state = ST_EMPTY;
        if (r_sv) begin
            w_state = (r_cnt == '0) ? ST_LAST : ST_SHIFT;
        end
    end

    always_comb begin
        w_sr_nxt   = r_sr;
        w_sv_nxt   = r_sv;
        w_cnt_nxt  = r_cnt;
        w_hr_nxt   = r_hr;
        w_hv_nxt   = r_hv;
        w_done_nxt = 1'b0;
        case (w_state)
            ST_EMPTY: begin
                if (w_accept) begin
                    w_sr_nxt  = din;
                    w_sv_nxt  = 1'b1;
                    w_cnt_nxt = CNT_MAX;
                end
            end
            ST_SHIFT: begin
                if (w_xfer) begin
                    w_sr_nxt  = w_shifted;
                    w_cnt_nxt = r_cnt - CNT_ONE;
                end
                if (w_accept) begin
                    w_hr_nxt = din;
                    w_hv_nxt = 1'b1;
                end
            end
            ST_LAST: begin
                if (w_xfer) begin
                    w_done_nxt = 1'b1;
                    // A held word has priority; din cannot be accepted while hv is set.
                    if (r_hv) begin
                        w_sr_nxt  = r_hr;
                        w_cnt_nxt = CNT_MAX;
                        w_hv_nxt  = 1'b0;
                    end else if (w_accept) begin
                        w_sr_nxt  = din;
                        w_cnt_nxt = CNT_MAX;
                    end else begin
                        w_sv_nxt = 1'b0;
                    end
                end else if (w_accept) begin
                    w_hr_nxt = din;
                    w_hv_nxt = 1'b1;
                end
            end
            default: begin
                w_sv_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sr   <= '0;
            r_sv   <= 1'b0;
            r_cnt  <= '0;
            r_hr   <= '0;
            r_hv   <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_sr   <= w_sr_nxt;
            r_sv   <= w_sv_nxt;
            r_cnt  <= w_cnt_nxt;
            r_hr   <= w_hr_nxt;
            r_hv   <= w_hv_nxt;
            r_done <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_pwrite_shift.sv
// tb/tb_pwrite_shift.sv - self-checking bench for pwrite_shift in both byte orders
module tb_pwrite_shift;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        din_valid;
    logic        dout_ready;

    logic       m_din_ready, m_dout_valid, m_dout_last, m_busy, m_done;
    logic [7:0] m_dout;
    logic       l_din_ready, l_dout_valid, l_dout_last, l_busy, l_done;
    logic [7:0] l_dout;

    pwrite_shift #(.WRITE_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(m_din_ready), .dout(m_dout), .dout_valid(m_dout_valid),
        .dout_ready(dout_ready), .dout_last(m_dout_last), .busy(m_busy), .done(m_done)
    );

    pwrite_shift #(.WRITE_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .reset(reset), .din(din), .din_valid(din_valid),
        .din_ready(l_din_ready), .dout(l_dout), .dout_valid(l_dout_valid),
        .dout_ready(dout_ready), .dout_last(l_dout_last), .busy(l_busy), .done(l_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] din;
        logic [31:0] exp_m;
        logic [31:0] exp_l;
        bit          rnd;
    } vec_t;

    vec_t        vecs[6];
    logic [8:0]  q_m[$];
    logic [8:0]  q_l[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] cur_m, cur_l;
    bit          accepted;
    bit          rnd_rdy;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bytes, listed in emission order from the top byte down.
    task automatic push_exp(input logic [31:0] em, input logic [31:0] el);
        for (int k = 3; k >= 0; k--) begin
            q_m.push_back({(k == 0), em[k*8 +: 8]});
            q_l.push_back({(k == 0), el[k*8 +: 8]});
        end
    endtask

    task automatic step();
        logic [8:0] e;
        @(negedge clk);
        if (m_dout_valid && dout_ready) begin
            if (q_m.size() == 0) chk("m_unexpected_byte", {23'd0, m_dout_last, m_dout}, 32'h1ff);
            else begin
                e = q_m.pop_front();
                chk("m_byte", {23'd0, m_dout_last, m_dout}, {23'd0, e});
            end
        end
        if (l_dout_valid && dout_ready) begin
            if (q_l.size() == 0) chk("l_unexpected_byte", {23'd0, l_dout_last, l_dout}, 32'h1ff);
            else begin
                e = q_l.pop_front();
                chk("l_byte", {23'd0, l_dout_last, l_dout}, {23'd0, e});
            end
        end
        if (!m_dout_valid) chk("m_idle_zero", {24'd0, m_dout}, 32'd0);
        if (!l_dout_valid) chk("l_idle_zero", {24'd0, l_dout}, 32'd0);
        if (din_valid && m_din_ready && !accepted) begin
            push_exp(cur_m, cur_l);
            accepted = 1'b1;
        end
        @(posedge clk);
        #1;
        if (accepted) din_valid = 1'b0;
        if (rnd_rdy) dout_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic present(input logic [31:0] d, input logic [31:0] em, input logic [31:0] el);
        din       = d;
        din_valid = 1'b1;
        cur_m     = em;
        cur_l     = el;
        accepted  = 1'b0;
    endtask

    task automatic wait_accept(input string name);
        for (int n = 0; n < 100 && !accepted; n++) step();
        chk({name, "_accept"}, {31'd0, accepted}, 32'd1);
    endtask

    task automatic drain(input string name);
        for (int n = 0; n < 400 && (m_busy || l_busy); n++) step();
        chk({name, "_drain"}, {31'd0, m_busy | l_busy}, 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'hA1B2C3D4, 32'hA1B2C3D4, 32'hD4C3B2A1, 1'b0};
        vecs[1] = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b1};
        vecs[2] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
        vecs[3] = '{32'h01234567, 32'h01234567, 32'h67452301, 1'b1};
        vecs[4] = '{32'h80000001, 32'h80000001, 32'h01000080, 1'b0};
        vecs[5] = '{32'h5A5AA5A5, 32'h5A5AA5A5, 32'hA5A55A5A, 1'b1};

        reset = 1'b0; din = '0; din_valid = 1'b0; dout_ready = 1'b0;
        rnd_rdy = 1'b0; accepted = 1'b0; cur_m = '0; cur_l = '0;
        #2 reset = 1'b1;
        #1;
        chk("rst_dout_valid", {31'd0, m_dout_valid | l_dout_valid}, 32'd0);
        chk("rst_dout", {16'd0, m_dout, l_dout}, 32'd0);
        chk("rst_last_busy_done", {26'd0, m_dout_last, l_dout_last, m_busy, l_busy, m_done, l_done}, 32'd0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk("post_rst_din_ready", {30'd0, m_din_ready, l_din_ready}, 32'd3);

        // Single word: cycle-exact valid/last/done/busy timing.
        dout_ready = 1'b1;
        present(32'hA1B2C3D4, 32'hA1B2C3D4, 32'hD4C3B2A1);
        wait_accept("single");
        for (int k = 0; k < 4; k++) begin
            chk("single_valid", {31'd0, m_dout_valid}, 32'd1);
            chk("single_last", {31'd0, m_dout_last}, {31'd0, (k == 3)});
            chk("single_done_low", {31'd0, m_done}, 32'd0);
            step();
        end
        chk("single_done_pulse", {30'd0, m_done, l_done}, 32'd3);
        chk("single_idle", {29'd0, m_busy, m_dout_valid, m_dout_last}, 32'd0);
        chk("single_dout_zero", {24'd0, m_dout}, 32'd0);
        step();
        chk("single_done_once", {31'd0, m_done}, 32'd0);

        // Backpressure while B2 is showing.
        present(32'hA1B2C3D4, 32'hA1B2C3D4, 32'hD4C3B2A1);
        wait_accept("bp");
        step();
        dout_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("bp_hold_m", {23'd0, m_dout_valid, m_dout}, {23'd0, 1'b1, 8'hB2});
            chk("bp_hold_l", {23'd0, l_dout_valid, l_dout}, {23'd0, 1'b1, 8'hC3});
        end
        dout_ready = 1'b1;
        drain("bp");

        // Back-to-back words through the holding register, no bubbles.
        present(32'h11223344, 32'h11223344, 32'h44332211);
        wait_accept("b2b_first");
        present(32'h55667788, 32'h55667788, 32'h88776655);
        wait_accept("b2b_second");
        chk("b2b_din_ready_low", {31'd0, m_din_ready}, 32'd0);
        for (int k = 1; k <= 8; k++) begin
            chk("b2b_valid", {31'd0, m_dout_valid}, {31'd0, (k < 8)});
            chk("b2b_done", {31'd0, m_done}, {31'd0, (k == 4 || k == 8)});
            step();
        end
        drain("b2b");

        // Last byte transfers in the same cycle a new word is accepted.
        present(32'h11223344, 32'h11223344, 32'h44332211);
        wait_accept("simul_first");
        repeat (3) step();
        chk("simul_showing_last", {23'd0, m_dout_last, m_dout}, {23'd0, 1'b1, 8'h44});
        present(32'hDEADBEEF, 32'hDEADBEEF, 32'hEFBEADDE);
        step();
        chk("simul_accepted", {31'd0, accepted}, 32'd1);
        chk("simul_next_byte", {16'd0, m_dout, l_dout}, {16'd0, 8'hDE, 8'hEF});
        chk("simul_flags", {28'd0, m_dout_valid, m_din_ready, m_busy, m_done}, 32'hF);
        drain("simul");

        // Table-driven words, each drained; some under random backpressure.
        for (int i = 0; i < 6; i++) begin
            rnd_rdy = vecs[i].rnd;
            if (!rnd_rdy) dout_ready = 1'b1;
            present(vecs[i].din, vecs[i].exp_m, vecs[i].exp_l);
            wait_accept("table");
            drain("table");
        end

        // Same table as one continuous burst with random backpressure.
        rnd_rdy = 1'b1;
        for (int i = 0; i < 6; i++) begin
            present(vecs[i].din, vecs[i].exp_m, vecs[i].exp_l);
            wait_accept("burst");
        end
        drain("burst");
        rnd_rdy = 1'b0;

        // Reset mid-word with the holding register full.
        dout_ready = 1'b1;
        present(32'hA1B2C3D4, 32'hA1B2C3D4, 32'hD4C3B2A1);
        wait_accept("rst_mid_first");
        present(32'h55667788, 32'h55667788, 32'h88776655);
        wait_accept("rst_mid_second");
        step();
        chk("rst_mid_hr_full", {23'd0, m_din_ready, m_dout}, {23'd0, 1'b0, 8'hC3});
        din_valid = 1'b0;
        reset = 1'b1;
        #1;
        chk("rst_mid_valid", {31'd0, m_dout_valid | l_dout_valid}, 32'd0);
        chk("rst_mid_dout", {16'd0, m_dout, l_dout}, 32'd0);
        chk("rst_mid_flags", {26'd0, m_dout_last, l_dout_last, m_busy, l_busy, m_done, l_done}, 32'd0);
        q_m.delete();
        q_l.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_mid_din_ready", {30'd0, m_din_ready, l_din_ready}, 32'd3);
        for (int k = 0; k < 3; k++) begin
            step();
            chk("rst_mid_no_residual", {29'd0, m_dout_valid, l_dout_valid, m_busy}, 32'd0);
        end
        present(32'hCAFEF00D, 32'hCAFEF00D, 32'h0DF0FECA);
        wait_accept("rst_mid_new");
        drain("rst_mid_new");

        chk("queues_empty", q_m.size() + q_l.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
